spi_master_multi_cs: RTL

SPI_MASTER_MULTI_CS -- requirements
Module: spi_master_multi_cs

---
 rtl/spi_pkg.sv | 29 ++
 rtl/spi_sck_gen.sv | 44 ++++
 rtl/spi_master_multi_cs.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state, configuration types and constants for the multi-CS SPI master
package spi_pkg;

    localparam int SPI_DIV_MAX_W = 32;
    localparam logic [SPI_DIV_MAX_W-1:0] SPI_MIN_HALF_PERIOD = 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CS_SETUP  = 3'd1,
        SHIFT     = 3'd2,
        NEXT_WAIT = 3'd3,
        CS_HOLD   = 3'd4,
        CS_OFF    = 3'd5
    } spi_master_state_t;

    typedef struct packed {
        logic                     cpol;
        logic                     cpha;
        logic [SPI_DIV_MAX_W-1:0] half_period;
    } spi_cfg_t;

    // A programmed half-period of 0 behaves exactly like 1.
    function automatic logic [SPI_DIV_MAX_W-1:0] spi_eff_half_period(
        input logic [SPI_DIV_MAX_W-1:0] hp
    );
        return (hp < SPI_MIN_HALF_PERIOD) ? SPI_MIN_HALF_PERIOD : hp;
    endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// rtl/spi_sck_gen.sv - half-period counter producing per-edge strobes for the SPI master
module spi_sck_gen
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     en,
    input  logic                     shift,
    input  logic [SPI_DIV_MAX_W-1:0] half_period,
    output logic                     tick,
    output logic                     lead_edge,
    output logic                     trail_edge,
    output logic                     last_edge
);

    localparam int EW = $clog2(2 * DATA_WIDTH);
    localparam logic [EW-1:0] FINAL_EDGE = EW'(2 * DATA_WIDTH - 1);

    logic [SPI_DIV_MAX_W-1:0] cnt_q, cnt_d;
    logic [EW-1:0]            edge_cnt_q, edge_cnt_d;

    // Even edge indices move SCK away from CPOL, odd ones bring it back.
    always_comb begin
        tick       = en && (cnt_q == half_period - SPI_DIV_MAX_W'(1));
        lead_edge  = shift && tick && !edge_cnt_q[0];
        trail_edge = shift && tick && edge_cnt_q[0];
        last_edge  = shift && tick && (edge_cnt_q == FINAL_EDGE);
        cnt_d      = (!en || tick) ? '0 : cnt_q + 1'b1;
        edge_cnt_d = !shift ? '0 : (tick ? edge_cnt_q + 1'b1 : edge_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            edge_cnt_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            edge_cnt_q <= edge_cnt_d;
        end
    end

endmodule

// File: rtl/spi_master_multi_cs.sv
// rtl/spi_master_multi_cs.sv - stream-fed SPI master with per-frame chip select; SPI_MASTER_LOOPBACK_EN adds cfg_loopback
module spi_master_multi_cs
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_CS     = 4,
    parameter int DIV_WIDTH  = 16,
    localparam int DEST_W    = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    input  logic [DEST_W-1:0]     s_tdest,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    input  logic                  cfg_cpol,
    input  logic                  cfg_cpha,
    input  logic [DIV_WIDTH-1:0]  cfg_half_period,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso,
    output logic [NUM_CS-1:0]     cs_n,
    output logic                  busy
`ifdef SPI_MASTER_LOOPBACK_EN
    ,
    input  logic                  cfg_loopback
`endif
);

    spi_master_state_t     state_q, state_d;
    spi_cfg_t              cfg_q, cfg_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d, rx_q, rx_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [DEST_W-1:0]     dest_q, dest_d;
    logic                  last_q, last_d, mosi_q, mosi_d, sck_q, sck_d;
    logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic                  done_q, done_d, run_q;
    logic                  tick, lead_edge, trail_edge, last_edge;
    logic                  accept, cpha_next, sample_edge, shift_edge, cs_active, miso_int;

`ifdef SPI_MASTER_LOOPBACK_EN
    logic loop_q, loop_d;
    assign miso_int = loop_q ? mosi_q : miso;
`else
    assign miso_int = miso;
`endif

    spi_sck_gen #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_sck_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          ((state_q == CS_SETUP) || (state_q == SHIFT) ||
                      (state_q == CS_HOLD)  || (state_q == CS_OFF)),
        .shift       (state_q == SHIFT),
        .half_period (cfg_q.half_period),
        .tick        (tick),
        .lead_edge   (lead_edge),
        .trail_edge  (trail_edge),
        .last_edge   (last_edge)
    );

    // done_q marks the cycle where the finished word moves into the output
    // register; no new word may be taken until that load has happened.
    assign s_tready  = run_q && !done_q && (!out_valid_q || m_tready) &&
                       ((state_q == IDLE) || (state_q == NEXT_WAIT));
    assign accept    = s_tvalid && s_tready;
    assign cpha_next = (state_q == IDLE) ? cfg_cpha : cfg_q.cpha;
    assign sample_edge = cfg_q.cpha ? trail_edge : lead_edge;
    assign shift_edge  = cfg_q.cpha ? lead_edge : (trail_edge && !last_edge);
    assign cs_active = (state_q == CS_SETUP) || (state_q == SHIFT) ||
                       (state_q == NEXT_WAIT) || (state_q == CS_HOLD);

    always_comb begin
        cs_n = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            cs_n[i] = !(cs_active && (dest_q == DEST_W'(i)));
        end
    end

    always_comb begin
        state_d     = state_q;
        cfg_d       = cfg_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        dest_d      = dest_q;
        last_d      = last_q;
        mosi_d      = mosi_q;
        sck_d       = sck_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
        loop_d      = loop_q;
`endif

        if (out_valid_q && m_tready) out_valid_d = 1'b0;
        if (done_q) begin
            out_data_d  = rx_q;
            out_last_d  = last_q;
            out_valid_d = 1'b1;
        end

        // With CPHA=0 the MSB must already be on MOSI when CS falls.
        if (accept) begin
            last_d  = s_tlast;
            state_d = CS_SETUP;
            if (cpha_next) begin
                tx_d = s_tdata;
            end else begin
                tx_d   = s_tdata << 1;
                mosi_d = s_tdata[DATA_WIDTH-1];
            end
        end

        case (state_q)
            IDLE: begin
                sck_d = cfg_cpol;
                if (accept) begin
                    dest_d            = s_tdest;
                    cfg_d.cpol        = cfg_cpol;
                    cfg_d.cpha        = cfg_cpha;
                    cfg_d.half_period = spi_eff_half_period(SPI_DIV_MAX_W'(cfg_half_period));
`ifdef SPI_MASTER_LOOPBACK_EN
                    loop_d            = cfg_loopback;
`endif
                end
            end
            CS_SETUP: begin
                sck_d = cfg_q.cpol;
                if (tick) state_d = SHIFT;
            end
            SHIFT: begin
                if (lead_edge || trail_edge) sck_d = !sck_q;
                if (sample_edge) rx_d = {rx_q[DATA_WIDTH-2:0], miso_int};
                if (shift_edge) begin
                    mosi_d = tx_q[DATA_WIDTH-1];
                    tx_d   = tx_q << 1;
                end
                if (last_edge) begin
                    done_d  = 1'b1;
                    state_d = last_q ? CS_HOLD : NEXT_WAIT;
                end
            end
            NEXT_WAIT: ;
            CS_HOLD: if (tick) state_d = CS_OFF;
            CS_OFF:  if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cfg_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            dest_q      <= '0;
            last_q      <= 1'b0;
            mosi_q      <= 1'b0;
            sck_q       <= cfg_cpol;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            run_q       <= 1'b0;
`ifdef SPI_MASTER_LOOPBACK_EN
            loop_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cfg_q       <= cfg_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            dest_q      <= dest_d;
            last_q      <= last_d;
            mosi_q      <= mosi_d;
            sck_q       <= sck_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            run_q       <= 1'b1;
`ifdef SPI_MASTER_LOOPBACK_EN
            loop_q      <= loop_d;
`endif
        end
    end

    assign sck      = sck_q;
    assign mosi     = mosi_q;
    assign m_tdata  = out_data_q;
    assign m_tvalid = out_valid_q;
    assign m_tlast  = out_last_q;
    assign busy     = (state_q != IDLE);

endmodule
